// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
// Round-robin access controller sharing one single-port SRAM (registered
// read data, one cycle of latency) among PORT_NUM valid/busy requesters.
// One SRAM access is issued per cycle. Each read result is routed back to
// the port that issued it and is held there until the consumer takes it.

module mem_rr_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int PORT_NUM   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORT_NUM-1:0]              req_valid,
  output logic [PORT_NUM-1:0]              req_busy,
  input  logic [PORT_NUM-1:0]              req_write,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0]   req_addr,
  input  logic [PORT_NUM*DATA_WIDTH-1:0]   req_data,
  output logic [PORT_NUM-1:0]              rsp_valid,
  input  logic [PORT_NUM-1:0]              rsp_busy,
  output logic [PORT_NUM*DATA_WIDTH-1:0]   rsp_data,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data,
  output logic                             mem_write_req,
  input  logic [DATA_WIDTH-1:0]            mem_q
);

  localparam int PTR_W = $clog2(PORT_NUM);
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(PORT_NUM - 1);
  localparam logic [PTR_W:0]   PORT_CNT  = (PTR_W + 1)'(PORT_NUM);

  // Arbitration state
  logic [PTR_W-1:0]               r_rr_ptr;

  // Read tracking: at most one SRAM read is in flight at any time
  logic [PORT_NUM-1:0]            r_rd_pend;
  logic                           r_rd_inflight;
  logic [PTR_W-1:0]               r_rd_port;

  // Per-port response registers
  logic [PORT_NUM-1:0]            r_rsp_valid;
  logic [PORT_NUM*DATA_WIDTH-1:0] r_rsp_data;

  // Combinational arbitration results
  logic [PORT_NUM-1:0]            w_eligible;
  logic [PORT_NUM-1:0]            w_grant;
  logic                           w_grant_any;
  logic [PTR_W-1:0]               w_grant_idx;
  logic                           w_grant_rd;
  logic [PTR_W:0]                 w_sum;
  logic [PTR_W-1:0]               w_scan;

  // SRAM drive and response bookkeeping
  logic [ADDR_WIDTH-1:0]          w_mem_addr;
  logic [DATA_WIDTH-1:0]          w_mem_data;
  logic                           w_mem_write;
  logic [PORT_NUM-1:0]            w_capture;
  logic [PORT_NUM-1:0]            w_rsp_xfer;

  // A write can always go; a read needs no read outstanding for the port and
  // a response slot that is empty or draining this cycle.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      w_eligible[i] = req_valid[i] &&
                      (req_write[i] ||
                       (!r_rd_pend[i] && (!r_rsp_valid[i] || !rsp_busy[i])));
    end
  end

  // First eligible port searching upward from the pointer, wrapping around
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    w_sum       = '0;
    w_scan      = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
      if (w_sum >= PORT_CNT) begin
        w_sum = w_sum - PORT_CNT;
      end
      w_scan = w_sum[PTR_W-1:0];
      if (!w_grant_any && w_eligible[w_scan]) begin
        w_grant[w_scan] = 1'b1;
        w_grant_idx     = w_scan;
        w_grant_any     = 1'b1;
      end
    end
  end

  // Route the granted port's request onto the SRAM; idle cycles read address 0
  always_comb begin
    w_mem_addr  = '0;
    w_mem_data  = '0;
    w_mem_write = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (w_grant[i]) begin
        w_mem_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_mem_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_mem_write = req_write[i];
      end
    end
  end

  assign w_grant_rd = |(w_grant & ~req_write);

  // Which response slot receives mem_q this edge, and which slots drain
  always_comb begin
    w_capture = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      w_capture[i] = r_rd_inflight && (r_rd_port == PTR_W'(i));
    end
  end

  assign w_rsp_xfer = r_rsp_valid & ~rsp_busy;

  // Advance the round-robin pointer past the port just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      r_rr_ptr <= (w_grant_idx == LAST_PORT) ? '0 : w_grant_idx + PTR_W'(1);
    end
  end

  // Remember which port owns the read currently in the SRAM pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend     <= '0;
      r_rd_inflight <= 1'b0;
      r_rd_port     <= '0;
    end else begin
      r_rd_pend     <= w_grant & ~req_write;
      r_rd_inflight <= w_grant_rd;
      if (w_grant_rd) begin
        r_rd_port <= w_grant_idx;
      end
    end
  end

  // Capture SRAM data into the owner's slot; a capture beats a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (w_capture[i]) begin
          r_rsp_valid[i]                         <= 1'b1;
          r_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem_q;
        end else if (w_rsp_xfer[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign req_busy      = req_valid & ~w_grant;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign mem_addr      = w_mem_addr;
  assign mem_data      = w_mem_data;
  assign mem_write_req = w_mem_write;

endmodule
